lut_logic_eval: RTL and testbench

Parametrised, clocked successor to the lab's fixed sum-of-products switch-to-LED decoders. Each of `CHANNELS` output channels evaluates a run-time-programmable boolean function of its own `INPUTS`-bit switch slice through a truth table held in registers. A scan engine walks one channel's truth table and reports its minterm count. The block sits between the board switch bank and the LED bank.

---
 rtl/lut_logic_eval_pkg.sv | 28 ++
 rtl/lut_logic_eval_scanner.sv | 77 +++++++
 rtl/lut_logic_eval.sv | 82 ++++++++
 tb/tb_lut_logic_eval.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_logic_eval_pkg.sv
// Shared types and width helpers for the LUT evaluator and its minterm scanner.
package lut_eval_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

  localparam int DEF_INPUTS = 4;
  localparam int TABLE_W    = 2 ** DEF_INPUTS;

  // Truth-table width for a function of `inputs` variables.
  function automatic int table_width(input int inputs);
    return 2 ** inputs;
  endfunction

  // One extra bit so an all-ones table counts to TABLE_W without overflow.
  function automatic int count_width(input int inputs);
    return inputs + 1;
  endfunction

  // Channel-select width, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lut_logic_eval_scanner.sv
// Minterm scanner: walks one truth table bit per cycle and reports its popcount.
//
// state | meaning
// IDLE  | waiting for an accepted start
// SCAN  | accumulating table[idx], one bit per edge
// DONE  | count valid, done pulses for one cycle
module minterm_scanner
  import lut_eval_pkg::*;
#(
  parameter int INPUTS = 4,
  localparam int TW  = table_width(INPUTS),
  localparam int CNW = count_width(INPUTS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [TW-1:0]  tbl,
  output logic           busy,
  output logic           done,
  output logic [CNW-1:0] count
);

  scan_state_t       state_q, state_d;
  logic [INPUTS-1:0] idx_q, idx_d;
  logic [CNW-1:0]    acc_q, acc_d;
  logic [CNW-1:0]    count_d;
  logic [CNW-1:0]    bit_ext;

  assign bit_ext = CNW'(tbl[idx_q]);

  // State, index, accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      count   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      count   <= count_d;
    end
  end

  // Next-state logic; idx holds at the last position instead of wrapping.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    count_d = count;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      ST_SCAN: begin
        acc_d = acc_q + bit_ext;
        if (idx_q == INPUTS'(TW - 1)) begin
          count_d = acc_q + bit_ext;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + INPUTS'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: rtl/lut_logic_eval.sv
// Programmable truth-table LED decoder with per-channel tables and a popcount scanner.
module lut_logic_eval
  import lut_eval_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int INPUTS   = 4,
  localparam int TW  = table_width(INPUTS),
  localparam int CW  = sel_width(CHANNELS),
  localparam int CNW = count_width(INPUTS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CHANNELS*INPUTS-1:0] sw,
  output logic [CHANNELS-1:0]        led,
  input  logic                       cfg_we,
  input  logic [CW-1:0]              cfg_chan,
  input  logic [TW-1:0]              cfg_table,
  output logic                       cfg_ready,
  input  logic                       scan_start,
  input  logic [CW-1:0]              scan_chan,
  output logic                       busy,
  output logic                       done,
  output logic [CNW-1:0]             count
);

  logic [TW-1:0] tbl [CHANNELS];
  logic [TW-1:0] sel_tbl;
  logic [CW-1:0] scan_ch_q;
  logic          wr_ok;
  logic          start_ok;

  assign cfg_ready = ~busy;
  assign wr_ok     = cfg_we && cfg_ready &&
                     ({1'b0, cfg_chan} < (CW + 1)'(CHANNELS));
  assign start_ok  = scan_start && !busy &&
                     ({1'b0, scan_chan} < (CW + 1)'(CHANNELS));

  // Truth-table registers, replaced in full on an accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) tbl[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_ok && cfg_chan == CW'(c)) tbl[c] <= cfg_table;
      end
    end
  end

  // LED outputs look up the pre-write table, so a write shows up one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) led[c] <= tbl[c][sw[c*INPUTS +: INPUTS]];
    end
  end

  // Latch the scanned channel when a scan is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scan_ch_q <= '0;
    else if (start_ok) scan_ch_q <= scan_chan;
  end

  // Route the latched channel's table to the scanner.
  always_comb begin
    sel_tbl = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (scan_ch_q == CW'(c)) sel_tbl = tbl[c];
    end
  end

  minterm_scanner #(.INPUTS(INPUTS)) u_scanner (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_ok),
    .tbl   (sel_tbl),
    .busy  (busy),
    .done  (done),
    .count (count)
  );

endmodule

// File: tb/tb_lut_logic_eval.sv
// Self-checking bench for lut_logic_eval: LED vector table plus scan scoreboard.
module tb_lut_logic_eval;

  localparam int CH = 3;
  localparam int IN = 4;

  logic          clk;
  logic          rst_n;
  logic [11:0]   sw;
  logic [2:0]    led;
  logic          cfg_we;
  logic [1:0]    cfg_chan;
  logic [15:0]   cfg_table;
  logic          cfg_ready;
  logic          scan_start;
  logic [1:0]    scan_chan;
  logic          busy;
  logic          done;
  logic [4:0]    count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          chan;
    logic [15:0] tbl;
    logic [3:0]  sw;
    int          exp;
  } led_vec_t;

  typedef struct {
    string name;
    int    chan;
    int    exp;
  } sb_t;

  led_vec_t vecs [8];
  sb_t      sb [$];

  lut_logic_eval #(.CHANNELS(CH), .INPUTS(IN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw         (sw),
    .led        (led),
    .cfg_we     (cfg_we),
    .cfg_chan   (cfg_chan),
    .cfg_table  (cfg_table),
    .cfg_ready  (cfg_ready),
    .scan_start (scan_start),
    .scan_chan  (scan_chan),
    .busy       (busy),
    .done       (done),
    .count      (count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic write_tbl(input int chan, input logic [15:0] val);
    cfg_we    = 1;
    cfg_chan  = 2'(chan);
    cfg_table = val;
    tick();
    cfg_we    = 0;
  endtask

  task automatic run_scan(input int chan, input int exp, input bit interfere);
    int k, nb, nd, dk;
    sb_t e;
    scan_chan  = 2'(chan);
    scan_start = 1;
    sb.push_back('{name: "scan_count", chan: chan, exp: exp});
    tick();
    scan_start = 0;
    k = 0; nb = 0; nd = 0; dk = -1;
    while (k < 40) begin
      if (busy) nb++;
      if (done) begin
        nd++;
        dk = k;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check(e.name, int'(count), e.exp);
        end
      end
      if (interfere && k == 3) begin
        check("cfg_ready_during_scan", int'(cfg_ready), 0);
        cfg_we     = 1;
        cfg_chan   = 2'(chan);
        cfg_table  = 16'hFFFF;
        scan_start = 1;
        scan_chan  = 2'd0;
      end else begin
        cfg_we     = 0;
        scan_start = 0;
      end
      if (!busy) break;
      tick();
      k++;
    end
    cfg_we     = 0;
    scan_start = 0;
    check("scan_not_timed_out", int'(k < 40), 1);
    if (sb.size() != 0) begin
      check("scan_done_seen", 0, 1);
      sb.delete();
    end
    check("scan_busy_cycles", nb, 17);
    check("scan_done_pulses", nd, 1);
    check("scan_done_cycle", dk, 16);
    tick();
    check("scan_idle_after", int'(busy), 0);
    check("scan_count_held", int'(count), exp);
  endtask

  initial begin
    int saw_done, saw_busy;
    sb_t e;

    vecs[0] = '{chan: 0, tbl: 16'h6666, sw: 4'b0001, exp: 1};
    vecs[1] = '{chan: 0, tbl: 16'h6666, sw: 4'b0011, exp: 0};
    vecs[2] = '{chan: 1, tbl: 16'h8000, sw: 4'b1111, exp: 1};
    vecs[3] = '{chan: 1, tbl: 16'h8000, sw: 4'b1110, exp: 0};
    vecs[4] = '{chan: 2, tbl: 16'h0001, sw: 4'b0000, exp: 1};
    vecs[5] = '{chan: 2, tbl: 16'hFFFF, sw: 4'b1010, exp: 1};
    vecs[6] = '{chan: 0, tbl: 16'h1234, sw: 4'b0010, exp: 1};
    vecs[7] = '{chan: 0, tbl: 16'h1234, sw: 4'b0011, exp: 0};

    rst_n = 0; sw = 12'($urandom); cfg_we = 0; cfg_chan = 0; cfg_table = 0;
    scan_start = 0; scan_chan = 0;
    repeat (3) tick();
    check("rst_led", int'(led), 0);
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);

    #2 rst_n = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      sw = 12'($urandom);
      tick();
      check("tables_zero_led", int'(led), 0);
    end

    foreach (vecs[i]) begin
      write_tbl(vecs[i].chan, vecs[i].tbl);
      sw = '0;
      sw[vecs[i].chan*4 +: 4] = vecs[i].sw;
      sb.push_back('{name: $sformatf("led_vec%0d", i), chan: vecs[i].chan, exp: vecs[i].exp});
      tick();
      e = sb.pop_front();
      check(e.name, int'(led[e.chan]), e.exp);
    end

    write_tbl(1, 16'h0000);
    sw = 12'h050;
    cfg_we = 1; cfg_chan = 2'd1; cfg_table = 16'h0020;
    tick();
    cfg_we = 0;
    check("same_cycle_old_table", int'(led[1]), 0);
    tick();
    check("same_cycle_new_table", int'(led[1]), 1);

    write_tbl(0, 16'h6666);
    run_scan(0, 8, 0);
    write_tbl(2, 16'hFFFF);
    run_scan(2, 16, 0);
    write_tbl(1, 16'h0000);
    run_scan(1, 0, 0);

    scan_chan = 2'd3; scan_start = 1;
    tick();
    scan_start = 0;
    check("bad_chan_busy", int'(busy), 0);
    tick();
    check("bad_chan_busy_later", int'(busy), 0);
    check("bad_chan_done", int'(done), 0);

    write_tbl(1, 16'h00F0);
    run_scan(1, 4, 1);
    sw = 12'h000;
    tick();
    check("table_kept_bit0", int'(led[1]), 0);
    sw = 12'h040;
    tick();
    check("table_kept_bit4", int'(led[1]), 1);

    write_tbl(2, 16'hFFFF);
    run_scan(2, 16, 0);
    sw = 12'h123;
    scan_chan = 2'd0; scan_start = 1;
    tick();
    scan_start = 0;
    repeat (5) tick();
    check("pre_reset_busy", int'(busy), 1);
    rst_n = 0;
    #1;
    check("midscan_rst_busy", int'(busy), 0);
    check("midscan_rst_count", int'(count), 0);
    check("midscan_rst_done", int'(done), 0);
    check("midscan_rst_led", int'(led), 0);
    check("midscan_rst_cfg_ready", int'(cfg_ready), 1);
    #1 rst_n = 1;
    saw_done = 0; saw_busy = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) saw_done++;
      if (busy) saw_busy++;
    end
    check("no_done_after_reset", saw_done, 0);
    check("no_busy_after_reset", saw_busy, 0);
    check("led_after_reset", int'(led), 0);

    write_tbl(0, 16'h6666);
    run_scan(0, 8, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
